rom_seq: RTL and testbench

Address sequencer that sits directly upstream of a 32x4 synchronous ROM and downstream of it on the display side. It walks the ROM addresses from 0 to LEN-1 at a prescaled rate and waits out the ROM read latency. Each returned word is latched onto a registered LED output. Typical use: `rom_seq` drives the ROM `addr`, and the ROM `data` returns on `data_in`, so the board LEDs show one ROM word per period.

---
 rtl/rom_seq_pkg.sv | 25 ++
 rtl/rom_seq_if.sv | 38 +++
 rtl/rom_seq_prescaler.sv | 39 +++
 rtl/rom_seq.sv | 116 +++++++++++
 tb/tb_rom_seq.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rom_seq_pkg
//  Description : Shared types and helpers for the ROM address sequencer.
//                Holds the FSM state encoding and the counter-width helper
//                used by the sequencer and its prescaler.
//  Revision    : 1.0 - initial release
// ============================================================================
package rom_seq_pkg;

    // Sequencer states. The encoding is fixed so that state dumps stay
    // comparable with the original board firmware documentation.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SHOW = 2'd2
    } state_t;

    // Width of a counter that must hold 0..n-1, never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rom_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : rom_seq_if
//  Description : Control / ROM / display bundle of the ROM sequencer.
//                master : the sequencer (drives addr, leds, busy, done)
//                slave  : the controller + ROM side (drives start, stop,
//                         loop and the ROM read data)
//  Ports       : start_i, stop_i, loop_i  - pass control (level sampled)
//                addr_o    [AW-1:0]       - ROM address
//                data_in_i [DW-1:0]       - ROM read data
//                leds_o    [DW-1:0]       - last latched ROM word
//                busy_o, done_o           - status
//  Revision    : 1.0 - initial release
// ============================================================================
interface rom_seq_if #(
    parameter int AW = 5,
    parameter int DW = 4
) ();
    logic          start_i;
    logic          stop_i;
    logic          loop_i;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] data_in_i;
    logic [DW-1:0] leds_o;
    logic          busy_o;
    logic          done_o;

    modport master (
        input  start_i, stop_i, loop_i, data_in_i,
        output addr_o, leds_o, busy_o, done_o
    );

    modport slave (
        output start_i, stop_i, loop_i, data_in_i,
        input  addr_o, leds_o, busy_o, done_o
    );
endinterface
`default_nettype wire

// File: rtl/rom_seq_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : prescaler
//  Description : Free-running counter 0..TICKS-1 with synchronous clear and
//                a terminal-count flag while the count sits at TICKS-1.
//  Ports       : clk, rst  - clock, asynchronous active-high reset
//                clr_i     - synchronous clear (holds the count at 0)
//                tc_o      - high while the count equals TICKS-1
//  Revision    : 1.0 - initial release
// ============================================================================
module prescaler
    import rom_seq_pkg::*;
#(
    parameter int TICKS = 12000000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr_i,
    output logic      tc_o
);
    localparam int             CNT_W  = cnt_width(TICKS);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TICKS - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i || (cnt_q == c_LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tc_o = (cnt_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/rom_seq.sv
`default_nettype none
// ============================================================================
//  Module      : rom_seq
//  Description : Walks ROM addresses 0..LEN-1, waits RD_LAT cycles for each
//                read, latches the word onto the LEDs and shows it for TICKS
//                cycles. Optional looping, abort via stop.
//  Ports       : clk, rst  - clock, asynchronous active-high reset
//                bus       - rom_seq_if.master (control, ROM, display)
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_seq
    import rom_seq_pkg::*;
#(
    parameter int AW     = 5,
    parameter int DW     = 4,
    parameter int LEN    = 8,
    parameter int TICKS  = 12000000,
    parameter int RD_LAT = 2
) (
    input  wire logic  clk,
    input  wire logic  rst,
    rom_seq_if.master  bus
);
    localparam int               LAT_W       = cnt_width(RD_LAT);
    localparam logic [LAT_W-1:0] c_LAT_LAST  = LAT_W'(RD_LAT - 1);
    localparam logic [AW-1:0]    c_LAST_ADDR = AW'(LEN - 1);

    state_t           state_q;
    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    leds_q;
    logic             busy_q;
    logic             done_q;
    logic [LAT_W-1:0] lat_q;

    logic w_pre_clr;
    logic w_pre_tc;

    // The display counter only runs while a word is on show; everywhere else
    // it is held at zero so each SHOW starts a fresh TICKS-long period.
    assign w_pre_clr = (state_q != ST_SHOW);

    prescaler #(
        .TICKS (TICKS)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clr_i (w_pre_clr),
        .tc_o  (w_pre_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            leds_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lat_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start_i && !bus.stop_i) begin
                        addr_q  <= '0;
                        lat_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    lat_q <= lat_q + LAT_W'(1);
                    // stop wins over the pending ROM sample
                    if (bus.stop_i) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (lat_q == c_LAT_LAST) begin
                        leds_q  <= bus.data_in_i;
                        state_q <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (bus.stop_i) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (w_pre_tc) begin
                        if (addr_q != c_LAST_ADDR) begin
                            addr_q  <= addr_q + AW'(1);
                            lat_q   <= '0;
                            state_q <= ST_WAIT;
                        end else if (bus.loop_i) begin
                            // explicit wrap: LEN need not be a power of two
                            addr_q  <= '0;
                            lat_q   <= '0;
                            state_q <= ST_WAIT;
                        end else begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.addr_o = addr_q;
    assign bus.leds_o = leds_q;
    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_seq
//  Description : Self-checking bench for rom_seq. Three instances share one
//                stimulus stream: A (RD_LAT=2, LEN=8, posedge ROM),
//                B (RD_LAT=1, LEN=8, negedge ROM), C (RD_LAT=2, LEN=1,
//                posedge ROM). A timeline model predicts every output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_seq;
    localparam int TICKS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rom_seq_if #(.AW(5), .DW(4)) ifa ();
    rom_seq_if #(.AW(5), .DW(4)) ifb ();
    rom_seq_if #(.AW(5), .DW(4)) ifc ();

    rom_seq #(.AW(5), .DW(4), .LEN(8), .TICKS(TICKS), .RD_LAT(2)) u_a (
        .clk(clk), .rst(rst), .bus(ifa.master));
    rom_seq #(.AW(5), .DW(4), .LEN(8), .TICKS(TICKS), .RD_LAT(1)) u_b (
        .clk(clk), .rst(rst), .bus(ifb.master));
    rom_seq #(.AW(5), .DW(4), .LEN(1), .TICKS(TICKS), .RD_LAT(2)) u_c (
        .clk(clk), .rst(rst), .bus(ifc.master));

    // 32x4 ROM contents: rom[i] = i for i < 8, zero above
    function automatic logic [3:0] rom_val(input int a);
        return (a < 8) ? 4'(a) : 4'd0;
    endfunction

    initial begin
        ifa.data_in_i = '0;
        ifb.data_in_i = '0;
        ifc.data_in_i = '0;
    end
    always @(posedge clk) ifa.data_in_i <= rom_val(int'(ifa.addr_o));
    always @(negedge clk) ifb.data_in_i <= rom_val(int'(ifb.addr_o));
    always @(posedge clk) ifc.data_in_i <= rom_val(int'(ifc.addr_o));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Per-instance reference: a pass is a timeline of words of period
    // RD_LAT+TICKS starting at the start edge; the ROM word lands RD_LAT
    // edges into each period, the address advances at each period end.
    int lens [3] = '{8, 8, 1};
    int rdl  [3] = '{2, 1, 2};
    bit m_busy [3];
    bit m_done [3];
    int m_t0   [3];
    int m_addr [3];
    int m_leds [3];

    logic st, sp, lp;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive(input logic s, input logic p, input logic l);
        st = s; sp = p; lp = l;
        ifa.start_i = s; ifa.stop_i = p; ifa.loop_i = l;
        ifb.start_i = s; ifb.stop_i = p; ifb.loop_i = l;
        ifc.start_i = s; ifc.stop_i = p; ifc.loop_i = l;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_busy[k] = 1'b0; m_done[k] = 1'b0;
            m_t0[k] = 0; m_addr[k] = 0; m_leds[k] = 0;
        end
    endtask

    task automatic model_step();
        int e, p;
        for (int k = 0; k < 3; k++) begin
            m_done[k] = 1'b0;
            p = rdl[k] + TICKS;
            if (!m_busy[k]) begin
                if (st && !sp) begin
                    m_busy[k] = 1'b1; m_t0[k] = cyc; m_addr[k] = 0;
                end
            end else if (sp) begin
                m_busy[k] = 1'b0;
            end else begin
                e = cyc - m_t0[k];
                if ((e % p) == rdl[k]) m_leds[k] = int'(rom_val(m_addr[k]));
                if ((e % p) == 0) begin
                    if (m_addr[k] != lens[k] - 1) m_addr[k]++;
                    else if (lp) m_addr[k] = 0;
                    else begin m_busy[k] = 1'b0; m_done[k] = 1'b1; end
                end
            end
        end
    endtask

    task automatic check_all();
        int oa[3], ol[3], ob[3], od[3];
        oa[0] = int'(ifa.addr_o); ol[0] = int'(ifa.leds_o); ob[0] = int'(ifa.busy_o); od[0] = int'(ifa.done_o);
        oa[1] = int'(ifb.addr_o); ol[1] = int'(ifb.leds_o); ob[1] = int'(ifb.busy_o); od[1] = int'(ifb.done_o);
        oa[2] = int'(ifc.addr_o); ol[2] = int'(ifc.leds_o); ob[2] = int'(ifc.busy_o); od[2] = int'(ifc.done_o);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("addr%0d", k), oa[k], m_addr[k]);
            check($sformatf("leds%0d", k), ol[k], m_leds[k]);
            check($sformatf("busy%0d", k), ob[k], int'(m_busy[k]));
            check($sformatf("done%0d", k), od[k], int'(m_done[k]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int n_start, done_a, done_c, cnt_done, found;

        // ---------------- reset ----------------
        drive(1'b0, 1'b0, 1'b0);
        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all();

        // ---------------- single pass ----------------
        drive(1'b1, 1'b0, 1'b0);
        step();
        n_start = cyc;
        drive(1'b0, 1'b0, 1'b0);
        done_a = -1; done_c = -1; cnt_done = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (ifa.done_o) begin
                cnt_done++;
                if (done_a < 0) done_a = cyc - n_start;
            end
            if (ifc.done_o && done_c < 0) done_c = cyc - n_start;
        end
        check("pass_done_lat_A", done_a, 48);
        check("pass_done_cnt_A", cnt_done, 1);
        check("pass_done_lat_C", done_c, 6);
        check("pass_end_addr_A", int'(ifa.addr_o), 7);
        check("pass_end_leds_A", int'(ifa.leds_o), 7);
        check("pass_end_busy_A", int'(ifa.busy_o), 0);

        // ---------------- asynchronous reset mid-SHOW ----------------
        drive(1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0);
        repeat (10) step();
        check("pre_rst_leds_A", int'(ifa.leds_o), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_addr_A", int'(ifa.addr_o), 0);
        check("arst_leds_A", int'(ifa.leds_o), 0);
        check("arst_busy_A", int'(ifa.busy_o), 0);
        check("arst_addr_B", int'(ifb.addr_o), 0);
        check("arst_leds_B", int'(ifb.leds_o), 0);
        check("arst_busy_B", int'(ifb.busy_o), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check_all();

        // ---------------- loop mode ----------------
        drive(1'b1, 1'b0, 1'b1);
        step();
        drive(1'b0, 1'b0, 1'b1);
        cnt_done = 0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (ifa.done_o) cnt_done++;
        end
        check("loop_done_A", cnt_done, 0);
        drive(1'b0, 1'b0, 1'b0);
        repeat (50) step();

        // ---------------- abort in WAIT of address 3 ----------------
        drive(1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0);
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            step();
            if (m_busy[0] && m_addr[0] == 3 && ((cyc - m_t0[0]) % (rdl[0] + TICKS)) < rdl[0])
                found = 1;
        end
        check("abort_reached", found, 1);
        drive(1'b0, 1'b1, 1'b0);
        step();
        check("abort_busy_A", int'(ifa.busy_o), 0);
        check("abort_leds_A", int'(ifa.leds_o), 2);
        check("abort_addr_A", int'(ifa.addr_o), 3);
        check("abort_done_A", int'(ifa.done_o), 0);
        drive(1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b0);
        step();
        check("restart_addr_A", int'(ifa.addr_o), 0);
        check("restart_busy_A", int'(ifa.busy_o), 1);
        drive(1'b0, 1'b0, 1'b0);
        repeat (60) step();

        // ---------------- start+stop together in IDLE ----------------
        drive(1'b1, 1'b1, 1'b0);
        step();
        check("startstop_busy_A", int'(ifa.busy_o), 0);
        drive(1'b0, 1'b0, 1'b0);
        step();

        // ---------------- randomized traffic ----------------
        lp = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            logic s, p, l;
            s = (($urandom % 8) == 0);
            p = (($urandom % 50) == 0);
            l = lp;
            if (($urandom % 100) == 0) l = ~lp;
            drive(s, p, l);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
